// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for sprite pixel sources
package sprite_pkg;

    localparam int SPR_W          = 32;
    localparam int SPR_H          = 16;
    localparam int VIDEO_W        = 640;
    localparam int Y_POS          = 440;
    localparam int STEP           = 4;
    localparam int EXPLODE_FRAMES = 32;
    localparam int RESPAWN_FRAMES = 60;
    localparam int CNT_W          = 7;
    localparam int X_MAX          = VIDEO_W - SPR_W;
    localparam int X_START        = (VIDEO_W - SPR_W) / 2;

    // Colours are packed [7:6] blue, [5:3] green, [2:0] red
    localparam logic [7:0] COLOR_BLACK = 8'h00;
    localparam logic [7:0] SHIP_COLOR  = 8'b00_111_000;

    typedef enum logic [1:0] {
        ALIVE,
        EXPLODING,
        DEAD
    } ship_state_t;

    // Row 0 is the top row; bit SPR_W-1 of each row is the leftmost pixel.
    // Row 0 is solid so the full width of the box can be probed on one line.
    localparam logic [SPR_H-1:0][SPR_W-1:0] SHIP_BITMAP = {
        32'hFFFF_FFFF,  // row 15
        32'hFFFF_FFFF,  // row 14
        32'hFFFF_FFFF,  // row 13
        32'hFFFF_FFFF,  // row 12
        32'hFFFF_FFFF,  // row 11
        32'hFFFF_FFFF,  // row 10
        32'hFFFF_FFFF,  // row 9
        32'hFFFF_FFFF,  // row 8
        32'h7FFF_FFFE,  // row 7
        32'h3FFF_FFFC,  // row 6
        32'h0007_E000,  // row 5
        32'h0007_E000,  // row 4
        32'h0003_C000,  // row 3
        32'h0003_C000,  // row 2
        32'h0001_8000,  // row 1
        32'hFFFF_FFFF   // row 0
    };

endpackage

// File: rtl/sprite_hit_box.sv
// rtl/sprite_hit_box.sv - combinational box test and local pixel offsets for a sprite
module sprite_hit_box #(
    parameter int W   = 32,
    parameter int H   = 16,
    parameter int LXW = $clog2(W),
    parameter int LYW = $clog2(H)
) (
    input  logic [10:0]    pixel_x_i,
    input  logic [10:0]    pixel_y_i,
    input  logic [10:0]    box_x_i,
    input  logic [10:0]    box_y_i,
    output logic           inside_o,
    output logic [LXW-1:0] local_x_o,
    output logic [LYW-1:0] local_y_o
);

    // Compare on 12 bits so box_x + W cannot wrap near the top of the range
    always_comb begin
        inside_o  = ({1'b0, pixel_x_i} >= {1'b0, box_x_i}) &&
                    ({1'b0, pixel_x_i} <  ({1'b0, box_x_i} + 12'(W))) &&
                    ({1'b0, pixel_y_i} >= {1'b0, box_y_i}) &&
                    ({1'b0, pixel_y_i} <  ({1'b0, box_y_i} + 12'(H)));
        local_x_o = LXW'(pixel_x_i - box_x_i);
        local_y_o = LYW'(pixel_y_i - box_y_i);
    end

endmodule

// File: rtl/player_sprite_source.sv
// rtl/player_sprite_source.sv - player ship pixel source with per-frame motion and life FSM
module player_sprite_source
    import sprite_pkg::*;
(
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        moveLeft,
    input  logic        moveRight,
    input  logic        hit,
    output logic [7:0]  bgr_data_8,
    output logic        drawRequest,
    output logic [10:0] shipX,
    output logic        alive
);

    ship_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      x_q, x_d;
    logic             pend_q, pend_d;
    logic             draw_q, draw_d;
    logic [7:0]       bgr_q, bgr_d;
    logic             visible;
    logic             in_box;
    logic [4:0]       local_x;
    logic [3:0]       local_y;
    logic             bit_set;

    sprite_hit_box #(
        .W (SPR_W),
        .H (SPR_H)
    ) u_hit_box (
        .pixel_x_i (pixelX),
        .pixel_y_i (pixelY),
        .box_x_i   (x_q),
        .box_y_i   (11'(Y_POS)),
        .inside_o  (in_box),
        .local_x_o (local_x),
        .local_y_o (local_y)
    );

    // State, position and registered pixel outputs
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ALIVE;
            cnt_q   <= '0;
            x_q     <= 11'(X_START);
            pend_q  <= 1'b0;
            draw_q  <= 1'b0;
            bgr_q   <= COLOR_BLACK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            pend_q  <= pend_d;
            draw_q  <= draw_d;
            bgr_q   <= bgr_d;
        end
    end

    // Next state: everything except the hit latch moves only on startOfFrame
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        // A hit is remembered only while alive; otherwise it is dropped
        pend_d  = (state_q == ALIVE) ? (pend_q | hit) : 1'b0;
        if (startOfFrame) begin
            case (state_q)
                ALIVE: begin
                    pend_d = 1'b0;
                    if (pend_q || hit) begin
                        state_d = EXPLODING;
                        cnt_d   = '0;
                    end else if (moveLeft && !moveRight) begin
                        x_d = (x_q < 11'(STEP)) ? 11'd0 : x_q - 11'(STEP);
                    end else if (moveRight && !moveLeft) begin
                        x_d = (x_q >= 11'(X_MAX - STEP)) ? 11'(X_MAX) : x_q + 11'(STEP);
                    end
                end
                EXPLODING: begin
                    if (cnt_q == CNT_W'(EXPLODE_FRAMES - 1)) begin
                        state_d = DEAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DEAD: begin
                    if (cnt_q == CNT_W'(RESPAWN_FRAMES - 1)) begin
                        state_d = ALIVE;
                        cnt_d   = '0;
                        x_d     = 11'(X_START);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ALIVE;
                    cnt_d   = '0;
                    x_d     = 11'(X_START);
                end
            endcase
        end
    end

    // State-derived outputs: life flag and sprite visibility (blinks every 4 frames while exploding)
    always_comb begin
        alive   = 1'b0;
        visible = 1'b0;
        case (state_q)
            ALIVE: begin
                alive   = 1'b1;
                visible = 1'b1;
            end
            EXPLODING: visible = cnt_q[2];
            default:   visible = 1'b0;
        endcase
    end

    // Pixel lookup feeding the one-cycle output register
    always_comb begin
        bit_set = SHIP_BITMAP[local_y][5'(SPR_W - 1) - local_x];
        draw_d  = visible && in_box && bit_set;
        bgr_d   = draw_d ? SHIP_COLOR : COLOR_BLACK;
    end

    assign bgr_data_8  = bgr_q;
    assign drawRequest = draw_q;
    assign shipX       = x_q;

endmodule

// File: tb/tb_player_sprite_source.sv
// tb/tb_player_sprite_source.sv - self-checking bench for player_sprite_source
module tb_player_sprite_source;

    logic        clk;
    logic        rst_n;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        sof;
    logic        ml;
    logic        mr;
    logic        hit;
    logic [7:0]  bgr_data_8;
    logic        drawRequest;
    logic [10:0] shipX;
    logic        alive;

    int n_checks;
    int n_errors;

    player_sprite_source dut (
        .iVGA_CLK     (clk),
        .iRST_n       (rst_n),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (sof),
        .moveLeft     (ml),
        .moveRight    (mr),
        .hit          (hit),
        .bgr_data_8   (bgr_data_8),
        .drawRequest  (drawRequest),
        .shipX        (shipX),
        .alive        (alive)
    );

    always #5 clk = ~clk;

    logic [31:0] bm [16] = '{
        32'hFFFFFFFF, 32'h00018000, 32'h0003C000, 32'h0003C000,
        32'h0007E000, 32'h0007E000, 32'h3FFFFFFC, 32'h7FFFFFFE,
        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF
    };

    // Reference model: position, life flag, frames elapsed since the hit was taken
    int m_x;
    bit m_alive;
    int m_t;
    bit m_pend;

    function automatic void model_reset();
        m_x     = 304;
        m_alive = 1'b1;
        m_t     = 0;
        m_pend  = 1'b0;
    endfunction

    function automatic bit exp_draw(int px, int py);
        bit vis;
        logic [31:0] row;
        vis = m_alive || (m_t < 32 && ((m_t / 4) % 2 == 1));
        if (!vis) return 1'b0;
        if (px < m_x || px >= m_x + 32 || py < 440 || py >= 456) return 1'b0;
        row = bm[py - 440];
        return row[31 - (px - m_x)];
    endfunction

    function automatic void model_update(bit s, bit l, bit r, bit h);
        if (!s) begin
            if (m_alive && h) m_pend = 1'b1;
            if (!m_alive) m_pend = 1'b0;
        end else begin
            if (m_alive) begin
                if (m_pend || h) begin
                    m_alive = 1'b0;
                    m_t     = 0;
                end else if (l && !r) begin
                    m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
                end else if (r && !l) begin
                    m_x = (m_x + 4 > 608) ? 608 : m_x + 4;
                end
            end else begin
                m_t = m_t + 1;
                if (m_t == 92) begin
                    m_alive = 1'b1;
                    m_x     = 304;
                end
            end
            m_pend = 1'b0;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One pixel clock: drive, clock, then compare every output with the model
    task automatic step(input int px, input int py, input bit s, input bit l, input bit r, input bit h);
        bit ed;
        ed     = exp_draw(px, py);
        pixelX = 11'(px);
        pixelY = 11'(py);
        sof    = s;
        ml     = l;
        mr     = r;
        hit    = h;
        @(posedge clk);
        #1;
        model_update(s, l, r, h);
        chk("drawRequest", int'(drawRequest), int'(ed));
        chk("bgr_data_8", int'(bgr_data_8), ed ? 32'h38 : 32'h00);
        chk("shipX", int'(shipX), m_x);
        chk("alive", int'(alive), int'(m_alive));
    endtask

    task automatic rand_pixel(output int px, output int py);
        if ($urandom_range(0, 3) == 0) begin
            px = int'($urandom_range(0, 2047));
            py = int'($urandom_range(0, 2047));
        end else begin
            px = m_x + int'($urandom_range(0, 39)) - 4;
            if (px < 0) px = 0;
            py = 436 + int'($urandom_range(0, 23));
        end
    endtask

    task automatic frame(input bit l, input bit r, input bit h_sof);
        int px, py;
        for (int k = 0; k < 3; k++) begin
            rand_pixel(px, py);
            step(px, py, 1'b0, l, r, 1'b0);
        end
        step(640, 480, 1'b1, l, r, h_sof);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int px;
        int py;
        bit exp;
    } vec_t;

    vec_t vq[$];

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        pixelX = '0;
        pixelY = '0;
        sof    = 1'b0;
        ml     = 1'b0;
        mr     = 1'b0;
        hit    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_draw", int'(drawRequest), 0);
        chk("rst_bgr", int'(bgr_data_8), 0);
        chk("rst_alive", int'(alive), 1);
        chk("rst_shipX", int'(shipX), 304);
        rst_n = 1'b1;

        // Directed pixel table at the reset position
        for (int x = 304; x <= 335; x++) vq.push_back('{x, 440, 1'b1});
        vq.push_back('{303, 440, 1'b0});
        vq.push_back('{336, 440, 1'b0});
        vq.push_back('{319, 441, 1'b1});
        vq.push_back('{320, 441, 1'b1});
        vq.push_back('{318, 441, 1'b0});
        vq.push_back('{321, 441, 1'b0});
        vq.push_back('{335, 455, 1'b1});
        vq.push_back('{304, 456, 1'b0});
        vq.push_back('{304, 439, 1'b0});
        vq.push_back('{2047, 440, 1'b0});
        vq.push_back('{304, 2047, 1'b0});
        foreach (vq[i]) begin
            step(vq[i].px, vq[i].py, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("tbl_draw", int'(drawRequest), int'(vq[i].exp));
            chk("tbl_bgr", int'(bgr_data_8), vq[i].exp ? 32'h38 : 32'h00);
        end

        // Saturation at the right and left edges
        for (int f = 0; f < 100; f++) frame(1'b0, 1'b1, 1'b0);
        chk("sat_right", int'(shipX), 608);
        for (int f = 0; f < 200; f++) frame(1'b1, 1'b0, 1'b0);
        chk("sat_left", int'(shipX), 0);

        // Both directions held cancel out
        do_reset();
        for (int f = 0; f < 5; f++) frame(1'b1, 1'b1, 1'b0);
        chk("both_held", int'(shipX), 304);

        // Mid-frame hit, full explosion and respawn, with noise hits and motion
        step(100, 100, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("alive_before_sof", int'(alive), 1);
        frame(1'b0, 1'b0, 1'b0);
        chk("alive_fall", int'(alive), 0);
        for (int f = 0; f < 92; f++) begin
            step(320, 448, 1'b0, 1'b0, f >= 32, 1'b0);
            chk("blink_draw", int'(drawRequest), (f < 32 && ((f / 4) % 2 == 1)) ? 1 : 0);
            step(330, 450, 1'b0, 1'b0, f >= 32, (f % 7) == 3);
            frame(1'b0, f >= 32, (f % 11) == 5);
        end
        chk("respawn_alive", int'(alive), 1);
        chk("respawn_x", int'(shipX), 304);

        // Asynchronous reset while exploding and drawing
        step(100, 100, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 5; f++) frame(1'b0, 1'b0, 1'b0);
        step(320, 448, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_draw", int'(drawRequest), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_draw", int'(drawRequest), 0);
        chk("async_rst_bgr", int'(bgr_data_8), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_alive", int'(alive), 1);
        chk("post_rst_x", int'(shipX), 304);

        // Random frames against the model
        for (int f = 0; f < 300; f++) begin
            bit l, r;
            int px, py;
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            rand_pixel(px, py);
            step(px, py, 1'b0, l, r, $urandom_range(0, 15) == 0);
            frame(l, r, $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
